// File: rtl/es_pio_pkg.sv
// rtl/es_pio_pkg.sv - shared constants and helpers for the input PIO
package es_pio_pkg;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/es_pio_in_edge_if.sv
// rtl/es_pio_in_edge_if.sv - s1 register slave port of the input PIO
interface es_pio_in_edge_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/es_debounce_bit.sv
// rtl/es_debounce_bit.sv - single-bit debounce filter
module es_debounce_bit
   import es_pio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] cnt;

   // q only follows d after DEBOUNCE_CYCLES consecutive mismatching samples
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
         q   <= 1'b0;
      end else if (d == q) begin
         cnt <= '0;
      end else if (cnt == LAST) begin
         q   <= ~q;
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

endmodule

// File: rtl/es_pio_in_edge.sv
// rtl/es_pio_in_edge.sv - input PIO with sync, debounce, edge capture and irq
module es_pio_in_edge
   import es_pio_pkg::*;
#(
   parameter int WIDTH           = 1,
   parameter int DEBOUNCE_CYCLES = 0,
   parameter int EDGE_MODE       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_port,
   es_pio_in_edge_if.slave  s1
);

   logic [WIDTH-1:0] sync1, sync2;
   logic [WIDTH-1:0] stable, stable_d;
   logic [WIDTH-1:0] ev, clr;
   logic [WIDTH-1:0] edgecap, irqmask;
   logic [31:0]      rd_next;
   logic             wr;
   logic             unused_wdata;

   assign unused_wdata = ^s1.writedata;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= in_port;
         sync2 <= sync1;
      end
   end

   generate
      if (DEBOUNCE_CYCLES == 0) begin : g_bypass
         assign stable = sync2;
      end else begin : g_debounce
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            es_debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
               .clk   (clk),
               .reset (reset),
               .d     (sync2[i]),
               .q     (stable[i])
            );
         end
      end
   endgenerate

   always_comb begin
      case (EDGE_MODE)
         EDGE_RISE: ev = stable & ~stable_d;
         EDGE_FALL: ev = ~stable & stable_d;
         default:   ev = stable ^ stable_d;
      endcase
   end

   assign wr  = s1.chipselect & ~s1.write_n;
   assign clr = (wr && s1.address == ADDR_EDGECAP) ? s1.writedata[WIDTH-1:0] : '0;

   // a new edge in the same cycle as a clear keeps its bit set
   always_ff @(posedge clk) begin
      if (reset) begin
         stable_d <= '0;
         edgecap  <= '0;
         irqmask  <= '0;
      end else begin
         stable_d <= stable;
         edgecap  <= (edgecap & ~clr) | ev;
         if (wr && s1.address == ADDR_IRQMASK) irqmask <= s1.writedata[WIDTH-1:0];
      end
   end

   always_comb begin
      rd_next = '0;
      case (s1.address)
         ADDR_DATA:    rd_next[WIDTH-1:0] = stable;
         ADDR_IRQMASK: rd_next[WIDTH-1:0] = irqmask;
         ADDR_EDGECAP: rd_next[WIDTH-1:0] = edgecap;
         default:      rd_next = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) s1.readdata <= '0;
      else       s1.readdata <= rd_next;
   end

   assign s1.irq = |(edgecap & irqmask);

endmodule
